// File: rtl/risc_mc_core.sv
// risc_mc_core: multi-cycle 16-bit-ISA RISC core on one ready-handshake memory port; define RISC_ILLEGAL_TRAP_EN to halt on illegal opcodes.
module risc_mc_core #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              retire,
  output logic [ADDR_W-1:0] pc_dbg,
  output logic              halted
);
  localparam int SW = $clog2(DATA_W);
`ifdef RISC_ILLEGAL_TRAP_EN
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  localparam state_t ILL = HALT;
`else
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
  localparam state_t ILL = FETCH;
`endif
  state_t state, state_n;
  logic [ADDR_W-1:0] pc, ea, off, br_pc;
  logic [15:0] ir;
  logic [DATA_W-1:0] a, b, res, alu;
  logic [DATA_W-1:0] rf [8];
  logic [3:0] op;
  logic [2:0] rs1, rs2, rd;
  logic is_alu, is_ls, is_br, taken;
  assign op = ir[15:12];
  assign rs1 = ir[11:9];
  assign rs2 = ir[8:6];
  assign rd = ir[5:3];
  assign off = {{(ADDR_W-6){ir[5]}}, ir[5:0]};
  assign is_alu = op >= 4'd2 && op <= 4'd9;
  assign is_ls = op <= 4'd1;
  assign is_br = op >= 4'd11 && op <= 4'd13;
  assign taken = op == 4'd13 || (op == 4'd11 && a == b) || (op == 4'd12 && a != b);
  assign br_pc = op == 4'd13 ? (pc & ~ADDR_W'(12'hFFF)) | ADDR_W'(ir[11:0]) : pc + off;
  always_comb begin
    alu = '0;
    case (op)
      4'd2: alu = a + b;
      4'd3: alu = a - b;
      4'd4: alu = ~a;
      4'd5: alu = a << b[SW-1:0];
      4'd6: alu = a >> b[SW-1:0];
      4'd7: alu = a & b;
      4'd8: alu = a | b;
      4'd9: alu = DATA_W'(a < b);
      default: alu = '0;
    endcase
  end
  always_comb begin
    state_n = state;
    case (state)
      FETCH: state_n = mem_ready ? DECODE : FETCH;
      DECODE: state_n = EXEC;
      EXEC: state_n = is_alu ? WB : is_ls ? MEM : is_br ? FETCH : ILL;
      MEM: state_n = !mem_ready ? MEM : op == 4'd1 ? FETCH : WB;
      WB: state_n = FETCH;
      default: state_n = state;
    endcase
  end
  // reset gates the bus combinationally so a pending request drops at once
  assign mem_req = rst_n && (state == FETCH || state == MEM);
  assign mem_we = mem_req && state == MEM && op == 4'd1;
  assign mem_addr = !mem_req ? '0 : state == FETCH ? pc : ea;
  assign mem_wdata = mem_we ? b : '0;
  assign retire = state != FETCH && state_n == FETCH;
  assign pc_dbg = pc;
`ifdef RISC_ILLEGAL_TRAP_EN
  assign halted = state == HALT;
`else
  assign halted = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      pc <= RESET_PC;
      ir <= '0;
      a <= '0;
      b <= '0;
      res <= '0;
      ea <= '0;
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else begin
      state <= state_n;
      if (state == FETCH && mem_ready) begin
        ir <= mem_rdata[15:0];
        pc <= pc + 1'b1;
      end
      if (state == DECODE) begin
        a <= rf[rs1];
        b <= rf[rs2];
      end
      if (state == EXEC) begin
        res <= alu;
        ea <= ADDR_W'(a) + off;
        if (taken) pc <= br_pc;
      end
      if (state == MEM && mem_ready) res <= mem_rdata;
      if (state == WB) rf[op == 4'd0 ? rs2 : rd] <= res;
    end
  end
endmodule
